exe_alu_stage: RTL and testbench

- Execute-stage pipeline register wrapped around the 64-bit ALU datapath of the Y86-64 style core.
- Consumes decoded operands from the decode stage and computes valE = B op A (ADD/SUB/AND/XOR).
- Updates the condition-code register (ZF/SF/OF) and evaluates the branch/cmov condition.
- Presents a registered result to the memory stage over a valid/ready handshake.

---
 rtl/exe_alu_stage_if.sv | 38 +++
 rtl/exe_alu_stage.sv | 122 ++++++++++++
 tb/tb_exe_alu_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/exe_alu_stage_if.sv
// Decode-to-execute operand bus, execute-to-memory result bus and CC flag taps.
// Pure wiring; no storage or added latency.
// Backpressure: in_ready (stage -> decode), out_ready (memory -> stage).
interface exe_alu_stage_if #(
  parameter int WIDTH = 64
);
  // decode -> execute
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_alufun;
  logic [2:0]       in_cfun;
  logic             in_set_cc;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             flush;
  // execute -> memory
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cond;
  logic             out_illegal;
  // condition-code register contents
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;

  // Execute stage side
  modport slave (
    input  in_valid, in_alufun, in_cfun, in_set_cc, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_result, out_cond, out_illegal, cc_zf, cc_sf, cc_of
  );

  // Environment side (decode driver / memory sink)
  modport master (
    output in_valid, in_alufun, in_cfun, in_set_cc, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_result, out_cond, out_illegal, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/exe_alu_stage.sv
// Execute stage: valE = B op A (ADD/SUB/AND/XOR), CC update, branch/cmov condition.
// Latency: 1 cycle from accept to out_valid; one op per cycle when drained each cycle.
// Backpressure: in_ready = !out_valid || out_ready; output held stable while stalled.
module exe_alu_stage #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input logic           clk,
  input logic           rst,
  exe_alu_stage_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  // Single valid bit is the whole stage state
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_cond;
  logic             r_illegal;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_res;
  logic             w_zf;
  logic             w_sf;
  logic             w_of;
  logic             w_cond;
  logic             w_illegal;

  // Handshake: readiness ignores flush/rst; flush only blocks the accept
  assign w_in_ready = (r_state == ST_EMPTY) || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

  // ALU datapath and new flag values for the offered op
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (bus.in_alufun)
      ALU_ADD: begin
        w_res = bus.in_b + bus.in_a;
        w_of  = (bus.in_a[MSB] == bus.in_b[MSB]) && (w_res[MSB] != bus.in_b[MSB]);
      end
      ALU_SUB: begin
        w_res = bus.in_b - bus.in_a;
        w_of  = (bus.in_a[MSB] != bus.in_b[MSB]) && (w_res[MSB] != bus.in_b[MSB]);
      end
      ALU_AND: w_res = bus.in_b & bus.in_a;
      default: w_res = bus.in_b ^ bus.in_a;
    endcase
    w_zf = (w_res == '0);
    w_sf = w_res[MSB];
  end

  // Condition uses the CC value from before this op's own update
  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (bus.in_cfun)
      3'd0: w_cond = 1'b1;
      3'd1: w_cond = (r_sf ^ r_of) | r_zf;
      3'd2: w_cond = r_sf ^ r_of;
      3'd3: w_cond = r_zf;
      3'd4: w_cond = !r_zf;
      3'd5: w_cond = !(r_sf ^ r_of);
      3'd6: w_cond = !(r_sf ^ r_of) && !r_zf;
      default: w_illegal = 1'b1;
    endcase
  end

  // Valid bit: flush empties, accept fills, drain without accept empties
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else if (bus.flush) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      r_state <= ST_FULL;
    end else if (bus.out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  // Output payload only changes on accept, so it holds through stalls and drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_cond    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_result  <= w_res;
      r_cond    <= w_cond;
      r_illegal <= w_illegal;
    end
  end

  // CC register: written only by an accepted op that requests it; never rolled back
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_zf, r_sf, r_of} <= CC_RESET;
    end else if (w_accept && bus.in_set_cc) begin
      {r_zf, r_sf, r_of} <= {w_zf, w_sf, w_of};
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == ST_FULL);
  assign bus.out_result  = r_result;
  assign bus.out_cond    = r_cond;
  assign bus.out_illegal = r_illegal;
  assign bus.cc_zf       = r_zf;
  assign bus.cc_sf       = r_sf;
  assign bus.cc_of       = r_of;
endmodule

// File: tb/tb_exe_alu_stage.sv
// Directed bench for exe_alu_stage with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked there too.
// out_ready is driven explicitly by each step to exercise stall/drain/flush.
module tb_exe_alu_stage;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  exe_alu_stage_if #(.WIDTH(64)) bus ();

  exe_alu_stage #(.WIDTH(64), .CC_RESET(3'b100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [1:0] fn, input logic [2:0] cf,
                       input logic scc, input logic [63:0] a, input logic [63:0] b);
    bus.in_valid  = vld;
    bus.in_alufun = fn;
    bus.in_cfun   = cf;
    bus.in_set_cc = scc;
    bus.in_a      = a;
    bus.in_b      = b;
  endtask

  function automatic logic [2:0] cc();
    return {bus.cc_zf, bus.cc_sf, bus.cc_of};
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0);
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.out_result, 64'd0);
    chk("rst_cc", {61'd0, cc()}, 64'd4);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    chk("idle_valid", {63'd0, bus.out_valid}, 64'd0);

    // ADD 3+5
    drive(1'b1, 2'd0, 3'd0, 1'b1, 64'd5, 64'd3);
    step();
    chk("add_result", bus.out_result, 64'd8);
    chk("add_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("add_cc", {61'd0, cc()}, 64'd0);
    chk("add_cond", {63'd0, bus.out_cond}, 64'd1);
    chk("add_illegal", {63'd0, bus.out_illegal}, 64'd0);

    // SUB overflow: 0x8000.. - 1
    drive(1'b1, 2'd1, 3'd0, 1'b1, 64'd1, 64'h8000000000000000);
    step();
    chk("sub_ovf_result", bus.out_result, 64'h7FFFFFFFFFFFFFFF);
    chk("sub_ovf_cc", {61'd0, cc()}, 64'd1);

    // ADD wrap to zero, cond l evaluated on CC=001 -> 1
    drive(1'b1, 2'd0, 3'd2, 1'b1, 64'h10, 64'hFFFFFFFFFFFFFFF0);
    step();
    chk("wrap_result", bus.out_result, 64'd0);
    chk("wrap_cond_l", {63'd0, bus.out_cond}, 64'd1);
    chk("wrap_cc", {61'd0, cc()}, 64'd4);

    // XOR self, no CC write, cond e on ZF=1 -> 1
    drive(1'b1, 2'd3, 3'd3, 1'b0, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0);
    step();
    chk("xor_result", bus.out_result, 64'd0);
    chk("xor_cond_e", {63'd0, bus.out_cond}, 64'd1);
    chk("xor_cc_kept", {61'd0, cc()}, 64'd4);

    // Backpressure: ADD 1+1 offered while memory stage stalls
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0, 3'd4, 1'b1, 64'd1, 64'd1);
    #1;
    chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stall_result", bus.out_result, 64'd0);
      chk("stall_cc", {61'd0, cc()}, 64'd4);
      chk("stall_in_ready2", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    chk("bp_add_result", bus.out_result, 64'd2);
    chk("bp_add_cond_ne", {63'd0, bus.out_cond}, 64'd0);
    chk("bp_add_cc", {61'd0, cc()}, 64'd0);
    // back-to-back: SUB 5-1, cond ge on CC=000 -> 1
    drive(1'b1, 2'd1, 3'd5, 1'b1, 64'd1, 64'd5);
    step();
    chk("b2b_result", bus.out_result, 64'd4);
    chk("b2b_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("b2b_cond_ge", {63'd0, bus.out_cond}, 64'd1);
    drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0);
    step();
    chk("drain_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("drain_result_hold", bus.out_result, 64'd4);

    // Flush: ADD 3+2 accepted, then flush with SUB 5-5 offered under stall
    drive(1'b1, 2'd0, 3'd0, 1'b1, 64'd2, 64'd3);
    step();
    chk("pre_flush_result", bus.out_result, 64'd5);
    chk("pre_flush_cc", {61'd0, cc()}, 64'd0);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    drive(1'b1, 2'd1, 3'd0, 1'b1, 64'd5, 64'd5);
    step();
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_cc", {61'd0, cc()}, 64'd0);
    bus.flush = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0);
    step();
    chk("post_flush_valid", {63'd0, bus.out_valid}, 64'd0);

    // AND with cond g on CC=000 -> 1
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd2, 3'd6, 1'b1, 64'hF0F0, 64'hFF00);
    step();
    chk("and_result", bus.out_result, 64'hF000);
    chk("and_cond_g", {63'd0, bus.out_cond}, 64'd1);
    chk("and_cc", {61'd0, cc()}, 64'd0);

    // Illegal cfun, no CC write; hold under stall then reset
    drive(1'b1, 2'd0, 3'd7, 1'b0, 64'd7, 64'd8);
    step();
    bus.out_ready = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 1'b0, 64'd0, 64'd0);
    chk("ill_result", bus.out_result, 64'd15);
    chk("ill_cond", {63'd0, bus.out_cond}, 64'd0);
    chk("ill_flag", {63'd0, bus.out_illegal}, 64'd1);
    chk("ill_cc", {61'd0, cc()}, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst2_result", bus.out_result, 64'd0);
    chk("rst2_illegal", {63'd0, bus.out_illegal}, 64'd0);
    chk("rst2_cond", {63'd0, bus.out_cond}, 64'd0);
    chk("rst2_cc", {61'd0, cc()}, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
